// File: rtl/atm_transaction_if.sv
// rtl/atm_transaction_if.sv - Card-handling / front-panel bus for the ATM transaction engine
interface atm_transaction_if #(
    parameter int balance_width = 20
);
    logic                     auth_ok;
    logic [balance_width-1:0] balance;
    logic                     card_out;
    logic                     op_start;
    logic [1:0]               op_sel;
    logic [balance_width-1:0] amount;
    logic                     op_done;
    logic [balance_width-1:0] updated_balance;
    logic                     insufficient;
    logic                     limit_err;
    logic                     op_err;
    logic                     busy;
    logic                     session_active;
    logic                     timeout;

    modport master (
        output auth_ok, balance, card_out, op_start, op_sel, amount,
        input  op_done, updated_balance, insufficient, limit_err, op_err,
               busy, session_active, timeout
    );

    modport slave (
        input  auth_ok, balance, card_out, op_start, op_sel, amount,
        output op_done, updated_balance, insufficient, limit_err, op_err,
               busy, session_active, timeout
    );
endinterface

// File: rtl/atm_transaction.sv
// rtl/atm_transaction.sv - Session transaction engine: inquiry/withdraw/deposit with limit and idle timeout
module atm_transaction #(
    parameter int balance_width  = 20,
    parameter int max_withdraw   = 5000,
    parameter int timeout_cycles = 1000
) (
    input  logic              clk,
    input  logic              rst,
    atm_transaction_if.slave  bus
);
    localparam int W  = balance_width;
    localparam int CW = $clog2(timeout_cycles);
    localparam logic [CW-1:0] IDLE_LAST = CW'(timeout_cycles - 1);
    localparam logic [W:0]    MAXW      = (W + 1)'(max_withdraw);

    typedef enum logic [1:0] {S_IDLE, S_READY, S_EXEC} state_t;

    state_t         r_state;
    logic [W-1:0]   r_bal;
    logic [W-1:0]   r_sess_total;
    logic [CW-1:0]  r_idle_cnt;
    logic [1:0]     r_op_sel;
    logic [W-1:0]   r_amount;
    logic           r_op_done;
    logic [W-1:0]   r_updated_balance;
    logic           r_insufficient;
    logic           r_limit_err;
    logic           r_op_err;
    logic           r_timeout;

    // Sums are one bit wider so the limit and overflow checks see the carry
    logic [W:0]     w_wd_sum;
    logic [W:0]     w_dep_sum;
    logic [W-1:0]   w_new_bal;
    logic           w_insufficient;
    logic           w_limit_err;
    logic           w_op_err;
    logic           w_wd_commit;

    assign w_wd_sum  = {1'b0, r_sess_total} + {1'b0, r_amount};
    assign w_dep_sum = {1'b0, r_bal} + {1'b0, r_amount};

    always_comb begin
        w_new_bal      = r_bal;
        w_insufficient = 1'b0;
        w_limit_err    = 1'b0;
        w_op_err       = 1'b0;
        w_wd_commit    = 1'b0;
        case (r_op_sel)
            2'b00: ;
            2'b01: begin
                if (r_amount > r_bal) begin
                    w_insufficient = 1'b1;
                end else if (w_wd_sum > MAXW) begin
                    w_limit_err = 1'b1;
                end else begin
                    w_new_bal   = r_bal - r_amount;
                    w_wd_commit = 1'b1;
                end
            end
            2'b10: begin
                if (w_dep_sum[W]) begin
                    w_limit_err = 1'b1;
                end else begin
                    w_new_bal = w_dep_sum[W-1:0];
                end
            end
            default: w_op_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= S_IDLE;
            r_bal             <= '0;
            r_sess_total      <= '0;
            r_idle_cnt        <= '0;
            r_op_sel          <= 2'b00;
            r_amount          <= '0;
            r_op_done         <= 1'b0;
            r_updated_balance <= '0;
            r_insufficient    <= 1'b0;
            r_limit_err       <= 1'b0;
            r_op_err          <= 1'b0;
            r_timeout         <= 1'b0;
        end else begin
            r_op_done      <= 1'b0;
            r_insufficient <= 1'b0;
            r_limit_err    <= 1'b0;
            r_op_err       <= 1'b0;
            r_timeout      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.auth_ok && !bus.card_out) begin
                        r_bal        <= bus.balance;
                        r_sess_total <= '0;
                        r_idle_cnt   <= '0;
                        r_state      <= S_READY;
                    end
                end
                S_READY: begin
                    if (bus.card_out) begin
                        r_state <= S_IDLE;
                    end else if (bus.op_start) begin
                        r_op_sel   <= bus.op_sel;
                        r_amount   <= bus.amount;
                        r_idle_cnt <= '0;
                        r_state    <= S_EXEC;
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (bus.card_out) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_op_done         <= 1'b1;
                        r_updated_balance <= w_new_bal;
                        r_bal             <= w_new_bal;
                        r_insufficient    <= w_insufficient;
                        r_limit_err       <= w_limit_err;
                        r_op_err          <= w_op_err;
                        if (w_wd_commit) begin
                            r_sess_total <= w_wd_sum[W-1:0];
                        end
                        r_state <= S_READY;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.op_done         = r_op_done;
    assign bus.updated_balance = r_updated_balance;
    assign bus.insufficient    = r_insufficient;
    assign bus.limit_err       = r_limit_err;
    assign bus.op_err          = r_op_err;
    assign bus.timeout         = r_timeout;
    assign bus.busy            = (r_state == S_EXEC);
    assign bus.session_active  = (r_state != S_IDLE);
endmodule

// File: tb/tb_atm_transaction.sv
// tb/tb_atm_transaction.sv - Randomized scoreboard bench for atm_transaction
module tb_atm_transaction;
    localparam int  W    = 20;
    localparam int  MAXW = 5000;
    localparam int  TO   = 40;
    localparam longint BMAX = (64'd1 << W) - 1;

    typedef struct {
        int           due;
        logic [W-1:0] bal;
        logic [2:0]   flags;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   mon_en;
    exp_t q[$];
    logic [W-1:0] m_last_upd;
    longint m_bal;
    longint m_sess;

    atm_transaction_if #(.balance_width(W)) bus ();

    atm_transaction #(
        .balance_width (W),
        .max_withdraw  (MAXW),
        .timeout_cycles(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W+4:0] all_outs();
        return {bus.op_done, bus.insufficient, bus.limit_err, bus.op_err, bus.busy,
                bus.session_active, bus.timeout, bus.updated_balance} == '0 ? '0 : '1;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.op_done) begin
                if (q.size() == 0) begin
                    check("unexpected_op_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_cycle", cyc, e.due);
                    check("updated_balance", bus.updated_balance, e.bal);
                    check("flags_ins_lim_err", {bus.insufficient, bus.limit_err, bus.op_err}, e.flags);
                    m_last_upd = e.bal;
                end
            end else begin
                check("flags_outside_done", {bus.insufficient, bus.limit_err, bus.op_err}, 0);
                check("balance_hold", bus.updated_balance, m_last_upd);
            end
        end
    end

    task automatic model_push(input logic [1:0] sel, input logic [W-1:0] amt, input int due);
        exp_t   e;
        longint a;
        a = amt;
        e.due   = due;
        e.flags = 3'b000;
        case (sel)
            2'd1: begin
                if (a > m_bal) e.flags = 3'b100;
                else if (m_sess + a > MAXW) e.flags = 3'b010;
                else begin
                    m_bal  -= a;
                    m_sess += a;
                end
            end
            2'd2: begin
                if (m_bal + a > BMAX) e.flags = 3'b010;
                else m_bal += a;
            end
            2'd3: e.flags = 3'b001;
            default: ;
        endcase
        e.bal = m_bal[W-1:0];
        q.push_back(e);
    endtask

    task automatic start_session(input logic [W-1:0] bal);
        @(posedge clk); #1;
        bus.card_out = 1'b1;
        bus.auth_ok  = 1'b0;
        @(posedge clk); #1;
        bus.card_out = 1'b0;
        bus.auth_ok  = 1'b1;
        bus.balance  = bal;
        @(posedge clk); #1;
        bus.auth_ok  = 1'b0;
        bus.balance  = W'($urandom);
        m_bal  = bal;
        m_sess = 0;
        check("session_active_after_auth", bus.session_active, 1);
    endtask

    // abort: card_out during EXEC; dbl: op_start held into the EXEC cycle
    task automatic do_op(input logic [1:0] sel, input logic [W-1:0] amt, input bit abort, input bit dbl);
        @(posedge clk); #1;
        bus.op_start = 1'b1;
        bus.op_sel   = sel;
        bus.amount   = amt;
        if (!abort) model_push(sel, amt, cyc + 2);
        @(posedge clk); #1;
        check("busy_in_exec", bus.busy, 1);
        bus.op_start = dbl;
        bus.op_sel   = 2'($urandom);
        bus.amount   = W'($urandom);
        bus.card_out = abort;
        @(posedge clk); #1;
        bus.op_start = 1'b0;
        bus.card_out = 1'b0;
        if (abort) check("abort_goes_idle", bus.session_active, 0);
    endtask

    function automatic logic [W-1:0] rand_amt();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return m_bal[W-1:0];
            2: return W'($urandom_range(0, 3000));
            3: return W'($urandom);
            default: return W'($urandom_range(0, 600));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d;
        int t;
        n_cmp = 0;
        n_bad = 0;
        mon_en = 1'b0;
        m_last_upd = '0;
        rst = 1'b0;
        bus.auth_ok  = 1'b1;
        bus.balance  = W'($urandom);
        bus.card_out = 1'b0;
        bus.op_start = 1'b1;
        bus.op_sel   = 2'($urandom);
        bus.amount   = W'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 0);
        bus.auth_ok  = 1'b0;
        bus.op_start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", bus.session_active, 0);
        mon_en = 1'b1;

        start_session(W'(1000));
        do_op(2'd1, W'(300), 0, 0);
        do_op(2'd2, W'(50), 0, 0);
        do_op(2'd1, W'(800), 0, 0);
        do_op(2'd3, W'($urandom), 0, 0);
        do_op(2'd0, W'($urandom), 0, 1);

        start_session(W'(10000));
        do_op(2'd1, W'(3000), 0, 0);
        do_op(2'd1, W'(2000), 0, 0);
        do_op(2'd1, W'(1), 0, 0);

        start_session(W'(500));
        do_op(2'd1, W'(0), 0, 0);
        do_op(2'd2, W'(0), 0, 0);
        do_op(2'd1, W'(500), 0, 0);

        start_session(W'(777));
        do_op(2'd1, W'(100), 1, 0);

        start_session(W'(BMAX - 9));
        do_op(2'd2, W'(10), 0, 0);
        d = cyc;
        t = -1;
        for (int i = 0; i < TO + 10; i++) begin
            @(negedge clk);
            if (bus.timeout) begin
                t = cyc;
                break;
            end
        end
        check("timeout_cycle", t, d + TO);
        check("idle_after_timeout", bus.session_active, 0);
        @(negedge clk);
        check("timeout_single_pulse", bus.timeout, 0);

        for (int s = 0; s < 8; s++) begin
            if (s % 3 == 0) start_session(W'(BMAX - $urandom_range(0, 2000)));
            else start_session(W'($urandom_range(0, 20000)));
            for (int k = 0; k < 25; k++) begin
                do_op(2'($urandom), rand_amt(), 0, $urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end

        start_session(W'(4321));
        do_op(2'd2, W'(9), 0, 0);
        @(posedge clk); #1;
        bus.op_start = 1'b1;
        bus.op_sel   = 2'd1;
        bus.amount   = W'(21);
        @(posedge clk); #1;
        bus.op_start = 1'b0;
        check("busy_before_async_reset", bus.busy, 1);
        #2;
        rst = 1'b0;
        m_last_upd = '0;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
